// File: rtl/fpu_pkg.sv
// Shared types for the sequential floating-point add/subtract datapath.
package fpu_pkg;

  typedef enum logic [3:0] {
    EXACT     = 4'b0001,
    INEXACT   = 4'b0010,
    OVERFLOW  = 4'b0100,
    UNDERFLOW = 4'b1000
  } status_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADDSUB,
    NORM,
    ROUND,
    PACK
  } state_t;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input yields N.
module fpu_lzc #(
  parameter int N = 29
) (
  input  logic [N-1:0]             din,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int CW = $clog2(N + 1);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CW'(N);
    for (int unsigned i = 0; i < N; i++) begin
      if (din[i]) count = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with start/busy/done handshake
// and guard/round/sticky rounding (RNE or RTZ).
module fpu_addsub_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic                   clock100KHz,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic                   rnd_mode,
  input  logic [EXP_W+MAN_W:0]   op_A_in,
  input  logic [EXP_W+MAN_W:0]   op_B_in,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   data_out,
  output logic [3:0]             status_out
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 4;
  localparam int XW   = EXP_W + 2;
  localparam int LZW  = $clog2(MW + 1);
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic signed [XW-1:0] EMIN = XW'(1 - BIAS);
  localparam logic signed [XW-1:0] EOVF = XW'(2 ** EXP_W - 1);

  state_t                state;
  logic                  sa, sb, ovf_in, ovf_sign, rnd_r;
  logic [EXP_W-1:0]      ea, eb;
  logic [MW-1:0]         ma, mb;
  logic                  sx, sy;
  logic [MW-1:0]         mx, my;
  logic signed [XW-1:0]  rexp;
  logic                  rsign;
  logic [MW:0]           sum;
  logic [MW-1:0]         nm;
  logic                  uflow, zero;
  logic [MAN_W-1:0]      rman;
  logic                  inexact;

  logic [EXP_W-1:0] a_exp, b_exp;
  assign a_exp = op_A_in[W-2:MAN_W];
  assign b_exp = op_B_in[W-2:MAN_W];

  // ALIGN: larger exponent becomes X, Y is shifted right with sticky collection
  logic                  swap, xs_c, ys_c;
  logic [EXP_W-1:0]      ex_c, d;
  logic [MW-1:0]         xm_c, ym_c, ysh_c;
  logic [2*MW-1:0]       wide;

  always_comb begin
    swap = eb > ea;
    ex_c = swap ? eb : ea;
    d    = swap ? eb - ea : ea - eb;
    xm_c = swap ? mb : ma;
    ym_c = swap ? ma : mb;
    xs_c = swap ? sb : sa;
    ys_c = swap ? sa : sb;
    wide = {ym_c, {MW{1'b0}}} >> d;
    if (32'(d) > MW - 1) ysh_c = {{(MW-1){1'b0}}, |ym_c};
    else                 ysh_c = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
  end

  // ADDSUB: magnitude add or larger-minus-smaller
  logic [MW:0] sum_c;
  logic        sgn_c;

  always_comb begin
    if (sx == sy) begin
      sum_c = {1'b0, mx} + {1'b0, my};
      sgn_c = sx;
    end else if (mx > my) begin
      sum_c = {1'b0, mx - my};
      sgn_c = sx;
    end else if (my > mx) begin
      sum_c = {1'b0, my - mx};
      sgn_c = sy;
    end else begin
      sum_c = '0;
      sgn_c = 1'b0;
    end
  end

  // NORM
  logic [LZW-1:0]        lz;
  logic [MW-1:0]         nm_c;
  logic signed [XW-1:0]  nexp_c;
  logic                  uf_c, zero_c;

  fpu_lzc #(.N(MW)) u_lzc (
    .din   (sum[MW-1:0]),
    .count (lz)
  );

  always_comb begin
    zero_c = (sum == '0);
    if (sum[MW]) begin
      nm_c   = {sum[MW:2], sum[1] | sum[0]};
      nexp_c = rexp + XW'(1);
    end else begin
      nm_c   = sum[MW-1:0] << lz;
      nexp_c = rexp - $signed({{(XW-LZW){1'b0}}, lz});
    end
    uf_c = !sum[MW] && !zero_c && (nexp_c < EMIN);
  end

  // ROUND
  logic                  lsb, g, r, s, inc;
  logic [MAN_W+1:0]      rm;
  logic [MAN_W-1:0]      rman_c;
  logic signed [XW-1:0]  rexp_c;

  assign {lsb, g, r, s} = nm[3:0];

  always_comb begin
    inc = 1'b0;
    case (rnd_r)
      RND_RNE: inc = g & (r | s | lsb);
      RND_RTZ: inc = 1'b0;
      default: inc = 1'b0;
    endcase
    rm = {1'b0, nm[MW-1:3]} + (MAN_W+2)'(inc);
    if (rm[MAN_W+1]) begin
      rman_c = rm[MAN_W:1];
      rexp_c = rexp + XW'(1);
    end else begin
      rman_c = rm[MAN_W-1:0];
      rexp_c = rexp;
    end
  end

  logic signed [XW-1:0] pexp;
  assign pexp = rexp + XW'(BIAS);

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
      sa <= 1'b0; sb <= 1'b0; ovf_in <= 1'b0; ovf_sign <= 1'b0; rnd_r <= 1'b0;
      ea <= '0; eb <= '0; ma <= '0; mb <= '0;
      sx <= 1'b0; sy <= 1'b0; mx <= '0; my <= '0;
      rexp <= '0; rsign <= 1'b0; sum <= '0; nm <= '0;
      uflow <= 1'b0; zero <= 1'b0; rman <= '0; inexact <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            state    <= ALIGN;
            sa       <= op_A_in[W-1];
            sb       <= op_B_in[W-1] ^ op_sub;
            ea       <= a_exp;
            eb       <= b_exp;
            ma       <= (a_exp == '0) ? '0 : {1'b1, op_A_in[MAN_W-1:0], 3'b000};
            mb       <= (b_exp == '0) ? '0 : {1'b1, op_B_in[MAN_W-1:0], 3'b000};
            ovf_in   <= (&a_exp) | (&b_exp);
            ovf_sign <= (&a_exp) ? op_A_in[W-1] : (op_B_in[W-1] ^ op_sub);
            rnd_r    <= rnd_mode;
          end
        end
        ALIGN: begin
          sx    <= xs_c;
          sy    <= ys_c;
          mx    <= xm_c;
          my    <= ysh_c;
          rexp  <= $signed({2'b00, ex_c}) - XW'(BIAS);
          state <= ADDSUB;
        end
        ADDSUB: begin
          sum   <= sum_c;
          rsign <= sgn_c;
          state <= NORM;
        end
        NORM: begin
          nm    <= nm_c;
          rexp  <= nexp_c;
          uflow <= uf_c;
          zero  <= zero_c;
          state <= ROUND;
        end
        ROUND: begin
          rman    <= rman_c;
          rexp    <= rexp_c;
          inexact <= g | r | s;
          state   <= PACK;
        end
        PACK: begin
          if (ovf_in) begin
            data_out   <= {ovf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            status_out <= OVERFLOW;
          end else if (pexp >= EOVF) begin
            data_out   <= {rsign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            status_out <= OVERFLOW;
          end else if (uflow) begin
            data_out   <= {rsign, {(W-1){1'b0}}};
            status_out <= UNDERFLOW;
          end else if (zero) begin
            data_out   <= '0;
            status_out <= EXACT;
          end else begin
            data_out   <= {rsign, pexp[EXP_W-1:0], rman};
            status_out <= inexact ? INEXACT : EXACT;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Randomised and directed checks of fpu_addsub_seq against an exact-arithmetic model.
module tb_fpu_addsub_seq;

  localparam logic [3:0] S_EXACT   = 4'b0001;
  localparam logic [3:0] S_INEXACT = 4'b0010;
  localparam logic [3:0] S_OVF     = 4'b0100;
  localparam logic [3:0] S_UNF     = 4'b1000;

  logic        clock100KHz = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic        rnd_mode = 1'b0;
  logic [31:0] op_A_in = '0;
  logic [31:0] op_B_in = '0;
  logic        busy, done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int total = 0;
  int bad = 0;

  fpu_addsub_seq #(.EXP_W(6), .MAN_W(25)) dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .start       (start),
    .op_sub      (op_sub),
    .rnd_mode    (rnd_mode),
    .op_A_in     (op_A_in),
    .op_B_in     (op_B_in),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  always #5 clock100KHz = ~clock100KHz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Exact value arithmetic: operands become integers scaled to the smaller exponent,
  // then the true sum is rounded to 26 significant bits.
  function automatic void ref_addsub(input logic [31:0] a, input logic [31:0] b,
                                     input logic sub, input logic rnd,
                                     output logic [31:0] res, output logic [3:0] st);
    logic sa, sb, s, inx;
    int ea, eb, emin, e, p, k;
    logic [127:0] ma, mb, m, q, rem, half, one;
    one = 128'd1;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:25]);
    eb = int'(b[30:25]);
    res = '0;
    st = S_EXACT;
    s = 1'b0;
    inx = 1'b0;
    if (ea == 63 || eb == 63) begin
      res = {(ea == 63) ? sa : sb, 6'h3F, 25'h0};
      st = S_OVF;
    end else begin
      ma = (ea == 0) ? '0 : 128'({1'b1, a[24:0]});
      mb = (eb == 0) ? '0 : 128'({1'b1, b[24:0]});
      if (ea == 0) ea = eb;
      if (eb == 0) eb = ea;
      emin = (ea < eb) ? ea : eb;
      ma = ma << (ea - emin);
      mb = mb << (eb - emin);
      if (sa == sb) begin m = ma + mb; s = sa; end
      else if (ma >= mb) begin m = ma - mb; s = sa; end
      else begin m = mb - ma; s = sb; end
      if (m == '0) begin
        res = '0;
        st = S_EXACT;
      end else begin
        p = 0;
        for (int i = 0; i < 128; i++) if (m[i]) p = i;
        e = emin + p - 25;
        if (e < 1) begin
          res = {s, 31'h0};
          st = S_UNF;
        end else begin
          if (p <= 25) begin
            q = m << (25 - p);
          end else begin
            k = p - 25;
            q = m >> k;
            rem = m & ((one << k) - one);
            half = one << (k - 1);
            inx = (rem != '0);
            if (!rnd && (rem > half || (rem == half && q[0]))) q = q + one;
            if (q[26]) begin q = q >> 1; e++; end
          end
          if (e >= 63) begin
            res = {s, 6'h3F, 25'h0};
            st = S_OVF;
          end else begin
            res = {s, 6'(e), q[24:0]};
            st = inx ? S_INEXACT : S_EXACT;
          end
        end
      end
    end
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic rnd);
    @(negedge clock100KHz);
    op_A_in = a; op_B_in = b; op_sub = sub; rnd_mode = rnd; start = 1'b1;
    @(posedge clock100KHz);
    #1;
    start = 1'b0;
    op_A_in = $urandom; op_B_in = $urandom; op_sub = ~sub; rnd_mode = ~rnd;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clock100KHz);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic rnd,
                        input logic [31:0] wd, input logic [3:0] ws);
    int n;
    launch(a, b, sub, rnd);
    check_value({tag, ".busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check_value({tag, ".lat"}, n, 5);
    check_value({tag, ".data"}, data_out, wd);
    check_value({tag, ".stat"}, 32'(status_out), 32'(ws));
    @(posedge clock100KHz);
    #1;
    check_value({tag, ".pulse"}, 32'({busy, done}), 32'd0);
    check_value({tag, ".hold"}, data_out, wd);
  endtask

  initial begin
    logic [31:0] a, b, wd;
    logic [3:0]  ws;
    logic        sub, rnd;
    int n, ndone, first, ea, eb, r;

    #3 reset = 1'b0;
    repeat (2) @(posedge clock100KHz);
    #1;
    check_value("rst.busy", 32'(busy), 32'd0);
    check_value("rst.done", 32'(done), 32'd0);
    check_value("rst.data", data_out, 32'd0);
    check_value("rst.stat", 32'(status_out), 32'd0);
    @(negedge clock100KHz) reset = 1'b1;

    run_op("one_plus_one", 32'h3E000000, 32'h3E000000, 1'b0, 1'b0, 32'h40000000, S_EXACT);
    run_op("cancel",       32'h3E000000, 32'h3E000000, 1'b1, 1'b0, 32'h00000000, S_EXACT);
    run_op("tie_even",     32'h3E000000, 32'h0A000000, 1'b0, 1'b0, 32'h3E000000, S_INEXACT);
    run_op("tie_odd",      32'h3E000001, 32'h0A000000, 1'b0, 1'b0, 32'h3E000002, S_INEXACT);
    run_op("tie_rtz",      32'h3E000001, 32'h0A000000, 1'b0, 1'b1, 32'h3E000001, S_INEXACT);
    run_op("ovf",          32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 1'b0, 32'h7E000000, S_OVF);
    run_op("ovf_round",    32'h7DFFFFFF, 32'h48000000, 1'b0, 1'b0, 32'h7E000000, S_OVF);
    run_op("unf_pos",      32'h02000001, 32'h02000000, 1'b1, 1'b0, 32'h00000000, S_UNF);
    run_op("unf_neg",      32'h02000000, 32'h02000001, 1'b1, 1'b0, 32'h80000000, S_UNF);
    run_op("rnd_carry",    32'h3FFFFFFF, 32'h0A000000, 1'b0, 1'b0, 32'h40000000, S_INEXACT);
    run_op("far_rtz",      32'h3E000000, 32'h02000000, 1'b1, 1'b1, 32'h3DFFFFFF, S_INEXACT);
    run_op("far_rne",      32'h3E000000, 32'h02000000, 1'b1, 1'b0, 32'h3E000000, S_INEXACT);
    run_op("zero_a",       32'h00000000, 32'hBE123456, 1'b0, 1'b0, 32'hBE123456, S_EXACT);
    run_op("flush_a",      32'h00000123, 32'h3E000000, 1'b0, 1'b0, 32'h3E000000, S_EXACT);
    run_op("resv_in",      32'h7E000000, 32'h3E000000, 1'b0, 1'b0, 32'h7E000000, S_OVF);

    // start while busy must be dropped
    launch(32'h3E000000, 32'h3E000000, 1'b0, 1'b0);
    @(negedge clock100KHz);
    op_A_in = 32'h7DFFFFFF; op_B_in = 32'h7DFFFFFF; start = 1'b1;
    @(posedge clock100KHz);
    #1;
    start = 1'b0;
    ndone = 0;
    first = 0;
    for (int c = 2; c <= 14; c++) begin
      @(posedge clock100KHz);
      #1;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
    end
    check_value("ignore.count", ndone, 1);
    check_value("ignore.edge", first, 5);
    check_value("ignore.data", data_out, 32'h40000000);

    // back-to-back: second start issued during the done cycle
    launch(32'h3E000000, 32'h3E000000, 1'b0, 1'b0);
    wait_done(n);
    check_value("b2b.lat1", n, 5);
    check_value("b2b.data1", data_out, 32'h40000000);
    op_A_in = 32'h3E000001; op_B_in = 32'h0A000000; op_sub = 1'b0; rnd_mode = 1'b1; start = 1'b1;
    @(posedge clock100KHz);
    #1;
    start = 1'b0;
    check_value("b2b.busy", 32'(busy), 32'd1);
    wait_done(n);
    check_value("b2b.lat2", n + 1, 6);
    check_value("b2b.data2", data_out, 32'h3E000001);
    check_value("b2b.stat2", 32'(status_out), 32'(S_INEXACT));
    @(posedge clock100KHz);
    #1;

    // asynchronous reset in the middle of an operation
    launch(32'h3E000000, 32'h0A000000, 1'b0, 1'b0);
    repeat (3) @(posedge clock100KHz);
    #2;
    reset = 1'b0;
    #1;
    check_value("midrst.busy", 32'(busy), 32'd0);
    check_value("midrst.done", 32'(done), 32'd0);
    check_value("midrst.data", data_out, 32'd0);
    check_value("midrst.stat", 32'(status_out), 32'd0);
    @(negedge clock100KHz) reset = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge clock100KHz);
      #1;
      if (done || busy) ndone++;
    end
    check_value("midrst.quiet", ndone, 0);
    run_op("after_rst", 32'h3E000000, 32'h3E000000, 1'b0, 1'b0, 32'h40000000, S_EXACT);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      ea = (r < 3) ? 0 : (r < 5) ? 63 : int'($urandom_range(1, 62));
      case (int'($urandom_range(0, 2)))
        0:       eb = int'($urandom_range(0, 63));
        1:       eb = ea + int'($urandom_range(0, 4)) - 2;
        default: eb = ea;
      endcase
      if (eb < 0) eb = 0;
      if (eb > 63) eb = 63;
      a = {1'($urandom), 6'(ea), 25'($urandom)};
      b = {1'($urandom), 6'(eb), 25'($urandom)};
      if ($urandom_range(0, 3) == 0) b[24:0] = a[24:0] ^ 25'($urandom_range(0, 7));
      sub = 1'($urandom);
      rnd = 1'($urandom);
      ref_addsub(a, b, sub, rnd, wd, ws);
      run_op("random", a, b, sub, rnd, wd, ws);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
